// File: rtl/mips_bus_pkg.sv
// Shared types and defaults for the instruction/data memory bus arbiter.
package mips_bus_pkg;

    localparam int unsigned AddrW    = 32;
    localparam int unsigned DataW    = 32;
    localparam int unsigned MaxDcons = 4;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        D_BUSY   = 2'd1,
        IF_BUSY  = 2'd2,
        IF_DRAIN = 2'd3
    } arb_state_t;

    // Grant encodings
    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_IF   = 2'd1;
    localparam logic [1:0] GNT_D    = 2'd2;

    // Data port is older (M stage) and wins, unless fetch has been starved long enough
    function automatic logic [1:0] pickGrant(input logic dElig,
                                             input logic ifElig,
                                             input logic forceIf);
        logic [1:0] gnt;
        gnt = GNT_NONE;
        if (forceIf && ifElig) begin
            gnt = GNT_IF;
        end else if (dElig) begin
            gnt = GNT_D;
        end else if (ifElig) begin
            gnt = GNT_IF;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants completed while a fetch waits; flags when fetch must go next.
module arb_starve_cnt #(
    parameter int unsigned MAX_DCONS = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] consec,
    output logic             forceIf
);

    logic [CNT_W-1:0] consecNext;

    // Clear wins over increment; increment stops at the limit
    always_comb begin
        consecNext = consec;
        if (clr) begin
            consecNext = '0;
        end else if (inc && (consec != CNT_W'(MAX_DCONS))) begin
            consecNext = consec + CNT_W'(1);
        end
    end

    // Counter and registered force flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            consec  <= '0;
            forceIf <= 1'b0;
        end else begin
            consec  <= consecNext;
            forceIf <= (consecNext == CNT_W'(MAX_DCONS));
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-ported memory bus between the fetch and data ports, one transaction at a time.
module mem_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int unsigned AW        = AddrW,
    parameter int unsigned DW        = DataW,
    parameter int unsigned MAX_DCONS = MaxDcons
) (
    input  logic          clk,
    input  logic          rst,
    // instruction fetch port
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_abort,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    output logic          if_stall,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          d_stall,
    // memory side
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int unsigned CntW = $clog2(MAX_DCONS + 1);

    arb_state_t    state;
    arb_state_t    stateNext;

    logic          memReqNext;
    logic          memWeNext;
    logic [AW-1:0] memAddrNext;
    logic [DW-1:0] memWdataNext;
    logic [DW-1:0] ifRdataNext;
    logic [DW-1:0] dRdataNext;
    logic          ifReadyNext;
    logic          dReadyNext;

    logic          cntInc;
    logic          cntClr;
    logic [CntW-1:0] consec;
    logic          forceIf;

    logic          dElig;
    logic          ifElig;
    logic [1:0]    grant;

    // Stall requests toward the hazard unit
    assign if_stall = if_req & ~if_ready;
    assign d_stall  = d_req & ~d_ready;

    // A port being answered this cycle, or a fetch being flushed, cannot win the bus
    assign dElig  = d_req & ~d_ready;
    assign ifElig = if_req & ~if_ready & ~if_abort;
    assign grant  = pickGrant(dElig, ifElig, forceIf);

    arb_starve_cnt #(
        .MAX_DCONS (MAX_DCONS),
        .CNT_W     (CntW)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .inc     (cntInc),
        .clr     (cntClr),
        .consec  (consec),
        .forceIf (forceIf)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and next values of all registered outputs
    always_comb begin
        stateNext    = state;
        memReqNext   = mem_req;
        memWeNext    = mem_we;
        memAddrNext  = mem_addr;
        memWdataNext = mem_wdata;
        ifRdataNext  = if_rdata;
        dRdataNext   = d_rdata;
        ifReadyNext  = 1'b0;
        dReadyNext   = 1'b0;
        cntInc       = 1'b0;
        cntClr       = 1'b0;

        case (state)
            IDLE: begin
                if (grant == GNT_D) begin
                    memReqNext   = 1'b1;
                    memWeNext    = d_we;
                    memAddrNext  = d_addr;
                    memWdataNext = d_wdata;
                    stateNext    = D_BUSY;
                end else if (grant == GNT_IF) begin
                    memReqNext   = 1'b1;
                    memWeNext    = 1'b0;
                    memAddrNext  = if_addr;
                    stateNext    = IF_BUSY;
                end
            end

            D_BUSY: begin
                if (mem_ack) begin
                    memReqNext = 1'b0;
                    dReadyNext = 1'b1;
                    if (!mem_we) begin
                        dRdataNext = mem_rdata;
                    end
                    cntInc    = if_req;
                    cntClr    = ~if_req;
                    stateNext = IDLE;
                end
            end

            IF_BUSY: begin
                if (mem_ack) begin
                    memReqNext = 1'b0;
                    cntClr     = 1'b1;
                    stateNext  = IDLE;
                    // A flush arriving with the ack still kills the instruction
                    if (!if_abort) begin
                        ifRdataNext = mem_rdata;
                        ifReadyNext = 1'b1;
                    end
                end else if (if_abort) begin
                    stateNext = IF_DRAIN;
                end
            end

            IF_DRAIN: begin
                // Memory cannot be cancelled; wait out the access and drop its data
                if (mem_ack) begin
                    memReqNext = 1'b0;
                    cntClr     = 1'b1;
                    stateNext  = IDLE;
                end
            end

            default: begin
                stateNext  = IDLE;
                memReqNext = 1'b0;
            end
        endcase
    end

    // Registered bus and port outputs; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            mem_req   <= memReqNext;
            mem_we    <= memWeNext;
            mem_addr  <= memAddrNext;
            mem_wdata <= memWdataNext;
            if_rdata  <= ifRdataNext;
            d_rdata   <= dRdataNext;
            if_ready  <= ifReadyNext;
            d_ready   <= dReadyNext;
        end
    end

endmodule
